// File: rtl/reg_file_sb_if.sv
// -----------------------------------------------------------------------------
// reg_file_sb_if
// Bundles the register-file side of the decode stage: two read ports, two write
// ports (low/high, the high port carries the upper MUL result) and the issue
// information that feeds the pending-register scoreboard.
//
// Signals (direction given from the register file's point of view):
//   reg_readnum_src / reg_readnum_dst       in   read indices
//   reg1_read_src / reg2_read_dst           out  read data
//   reg_write_low/high, reg_dst_low/high,
//   data_to_be_written_low/high             in   writeback ports
//   issue_valid, issue_wr_low/high,
//   issue_dst_low/high                      in   destinations marked pending
//   src_busy, dst_busy, hazard              out  RAW hazard indication
//   pending                                 out  scoreboard bit per register
// Modports: master = decode/writeback side, slave = register file.
// -----------------------------------------------------------------------------
interface reg_file_sb_if #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
);
  logic [ADDR_W-1:0]   reg_readnum_src;
  logic [ADDR_W-1:0]   reg_readnum_dst;
  logic [DATA_W-1:0]   reg1_read_src;
  logic [DATA_W-1:0]   reg2_read_dst;
  logic                reg_write_low;
  logic [ADDR_W-1:0]   reg_dst_low;
  logic [DATA_W-1:0]   data_to_be_written_low;
  logic                reg_write_high;
  logic [ADDR_W-1:0]   reg_dst_high;
  logic [DATA_W-1:0]   data_to_be_written_high;
  logic                issue_valid;
  logic                issue_wr_low;
  logic                issue_wr_high;
  logic [ADDR_W-1:0]   issue_dst_low;
  logic [ADDR_W-1:0]   issue_dst_high;
  logic                src_busy;
  logic                dst_busy;
  logic                hazard;
  logic [NUM_REGS-1:0] pending;

  modport master (
    output reg_readnum_src, reg_readnum_dst,
    output reg_write_low, reg_dst_low, data_to_be_written_low,
    output reg_write_high, reg_dst_high, data_to_be_written_high,
    output issue_valid, issue_wr_low, issue_wr_high, issue_dst_low, issue_dst_high,
    input  reg1_read_src, reg2_read_dst,
    input  src_busy, dst_busy, hazard, pending
  );

  modport slave (
    input  reg_readnum_src, reg_readnum_dst,
    input  reg_write_low, reg_dst_low, data_to_be_written_low,
    input  reg_write_high, reg_dst_high, data_to_be_written_high,
    input  issue_valid, issue_wr_low, issue_wr_high, issue_dst_low, issue_dst_high,
    output reg1_read_src, reg2_read_dst,
    output src_busy, dst_busy, hazard, pending
  );
endinterface

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// NUM_REGS x DATA_W register file for the decode stage with two combinational
// read ports, two synchronous write ports (low wins on an index collision),
// optional same-cycle write-to-read bypass and a per-register scoreboard that
// flags RAW hazards to decode.
//
// Ports:
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-high; clears registers and pending bits
//   bus    reg_file_sb_if.slave, see the interface for the signal list
//
// Parameters: DATA_W, NUM_REGS (power of 2, >= 2), ADDR_W = log2(NUM_REGS),
//   BYPASS (1 = reads and busy see the current cycle's writeback).
// -----------------------------------------------------------------------------
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         reset,
  reg_file_sb_if.slave bus
);

  localparam logic BYP = (BYPASS != 0);

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_pending;

  logic [NUM_REGS-1:0] w_wr_low;
  logic [NUM_REGS-1:0] w_wr_high;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;

  logic [DATA_W-1:0]   w_stored_src;
  logic [DATA_W-1:0]   w_stored_dst;
  logic                w_src_busy;
  logic                w_dst_busy;

  // Per-register decode of the write and issue ports.
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
    assign w_wr_low[gi]  = bus.reg_write_low  && (bus.reg_dst_low  == ADDR_W'(gi));
    assign w_wr_high[gi] = bus.reg_write_high && (bus.reg_dst_high == ADDR_W'(gi));
    assign w_set[gi]     = bus.issue_valid &&
                           ((bus.issue_wr_low  && (bus.issue_dst_low  == ADDR_W'(gi))) ||
                            (bus.issue_wr_high && (bus.issue_dst_high == ADDR_W'(gi))));
    assign w_clr[gi]     = w_wr_low[gi] | w_wr_high[gi];
  end

  // Storage: low port has priority over high port for the same index.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wr_low[i])       r_regs[i] <= bus.data_to_be_written_low;
        else if (w_wr_high[i]) r_regs[i] <= bus.data_to_be_written_high;
      end
    end
  end

  // Scoreboard: set dominates clear so a newer producer keeps ownership.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_pending <= '0;
    else       r_pending <= w_set | (r_pending & ~w_clr);
  end

  // Forwarding mux applied on top of the stored value; low port first.
  function automatic logic [DATA_W-1:0] f_fwd(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored,
    input logic              wl,
    input logic [ADDR_W-1:0] dl,
    input logic [DATA_W-1:0] dlo,
    input logic              wh,
    input logic [ADDR_W-1:0] dh,
    input logic [DATA_W-1:0] dhi
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (BYP) begin
      if (wl && (dl == idx))      v = dlo;
      else if (wh && (dh == idx)) v = dhi;
    end
    return v;
  endfunction

  assign w_stored_src = r_regs[bus.reg_readnum_src];
  assign w_stored_dst = r_regs[bus.reg_readnum_dst];

  assign bus.reg1_read_src = f_fwd(bus.reg_readnum_src, w_stored_src,
                                   bus.reg_write_low, bus.reg_dst_low, bus.data_to_be_written_low,
                                   bus.reg_write_high, bus.reg_dst_high, bus.data_to_be_written_high);
  assign bus.reg2_read_dst = f_fwd(bus.reg_readnum_dst, w_stored_dst,
                                   bus.reg_write_low, bus.reg_dst_low, bus.data_to_be_written_low,
                                   bus.reg_write_high, bus.reg_dst_high, bus.data_to_be_written_high);

  // With bypass, a writeback landing this cycle already resolves the hazard.
  assign w_src_busy = r_pending[bus.reg_readnum_src] & ~(BYP & w_clr[bus.reg_readnum_src]);
  assign w_dst_busy = r_pending[bus.reg_readnum_dst] & ~(BYP & w_clr[bus.reg_readnum_dst]);

  assign bus.src_busy = w_src_busy;
  assign bus.dst_busy = w_dst_busy;
  assign bus.hazard   = w_src_busy | w_dst_busy;
  assign bus.pending  = r_pending;

endmodule

// File: tb/tb_reg_file_sb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_sb
// Drives one stimulus stream into three register files (8x16 with and without
// bypass, 16x32 with bypass). A reference model computes each cycle's expected
// outputs, which are queued and compared by an independent monitor.
// -----------------------------------------------------------------------------
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  src, dst, dl, dh, idl, idh;
    logic        wl, wh, iv, iwl, iwh;
    logic [31:0] dlo, dhi;
  } stim_t;

  typedef struct {
    logic [31:0] src1, dst1, src0, dst0, srcw, dstw;
    logic        sb1, db1, sb0, db0, sbw, dbw;
    logic [7:0]  pn;
    logic [15:0] pw;
  } exp_t;

  stim_t s, nx;
  exp_t  q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model state
  logic [15:0] m_n [8];
  logic [7:0]  m_np;
  logic [31:0] m_w [16];
  logic [15:0] m_wp;

  reg_file_sb_if #(.DATA_W(16), .NUM_REGS(8),  .ADDR_W(3)) if_b1 ();
  reg_file_sb_if #(.DATA_W(16), .NUM_REGS(8),  .ADDR_W(3)) if_b0 ();
  reg_file_sb_if #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4)) if_w  ();

  reg_file_sb #(.DATA_W(16), .NUM_REGS(8),  .ADDR_W(3), .BYPASS(1)) u_b1 (.clk(clk), .reset(reset), .bus(if_b1));
  reg_file_sb #(.DATA_W(16), .NUM_REGS(8),  .ADDR_W(3), .BYPASS(0)) u_b0 (.clk(clk), .reset(reset), .bus(if_b0));
  reg_file_sb #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .BYPASS(1)) u_w  (.clk(clk), .reset(reset), .bus(if_w));

  assign if_b1.reg_readnum_src = s.src[2:0];   assign if_b1.reg_readnum_dst = s.dst[2:0];
  assign if_b1.reg_write_low   = s.wl;         assign if_b1.reg_dst_low     = s.dl[2:0];
  assign if_b1.data_to_be_written_low  = s.dlo[15:0];
  assign if_b1.reg_write_high  = s.wh;         assign if_b1.reg_dst_high    = s.dh[2:0];
  assign if_b1.data_to_be_written_high = s.dhi[15:0];
  assign if_b1.issue_valid     = s.iv;         assign if_b1.issue_wr_low    = s.iwl;
  assign if_b1.issue_wr_high   = s.iwh;        assign if_b1.issue_dst_low   = s.idl[2:0];
  assign if_b1.issue_dst_high  = s.idh[2:0];

  assign if_b0.reg_readnum_src = s.src[2:0];   assign if_b0.reg_readnum_dst = s.dst[2:0];
  assign if_b0.reg_write_low   = s.wl;         assign if_b0.reg_dst_low     = s.dl[2:0];
  assign if_b0.data_to_be_written_low  = s.dlo[15:0];
  assign if_b0.reg_write_high  = s.wh;         assign if_b0.reg_dst_high    = s.dh[2:0];
  assign if_b0.data_to_be_written_high = s.dhi[15:0];
  assign if_b0.issue_valid     = s.iv;         assign if_b0.issue_wr_low    = s.iwl;
  assign if_b0.issue_wr_high   = s.iwh;        assign if_b0.issue_dst_low   = s.idl[2:0];
  assign if_b0.issue_dst_high  = s.idh[2:0];

  assign if_w.reg_readnum_src  = s.src;        assign if_w.reg_readnum_dst  = s.dst;
  assign if_w.reg_write_low    = s.wl;         assign if_w.reg_dst_low      = s.dl;
  assign if_w.data_to_be_written_low   = s.dlo;
  assign if_w.reg_write_high   = s.wh;         assign if_w.reg_dst_high     = s.dh;
  assign if_w.data_to_be_written_high  = s.dhi;
  assign if_w.issue_valid      = s.iv;         assign if_w.issue_wr_low     = s.iwl;
  assign if_w.issue_wr_high    = s.iwh;        assign if_w.issue_dst_low    = s.idl;
  assign if_w.issue_dst_high   = s.idh;

  // ---------------- reference model ----------------
  function automatic logic n_wr_hits(input logic [2:0] a);
    return (s.wl && s.dl[2:0] == a) || (s.wh && s.dh[2:0] == a);
  endfunction

  function automatic logic w_wr_hits(input logic [3:0] a);
    return (s.wl && s.dl == a) || (s.wh && s.dh == a);
  endfunction

  function automatic logic [31:0] n_rd(input logic [2:0] a, input bit byp);
    if (byp && s.wl && s.dl[2:0] == a) return {16'h0, s.dlo[15:0]};
    if (byp && s.wh && s.dh[2:0] == a) return {16'h0, s.dhi[15:0]};
    return {16'h0, m_n[a]};
  endfunction

  function automatic logic [31:0] w_rd(input logic [3:0] a);
    if (s.wl && s.dl == a) return s.dlo;
    if (s.wh && s.dh == a) return s.dhi;
    return m_w[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++)  m_n[i] = 16'h0;
    for (int i = 0; i < 16; i++) m_w[i] = 32'h0;
    m_np = 8'h0;
    m_wp = 16'h0;
  endtask

  // Effect of one clock edge: high write, then low write (low wins), then
  // writeback clears pending, then issue sets it (issue wins).
  task automatic model_edge();
    if (s.wh) begin m_n[s.dh[2:0]] = s.dhi[15:0]; m_w[s.dh] = s.dhi; end
    if (s.wl) begin m_n[s.dl[2:0]] = s.dlo[15:0]; m_w[s.dl] = s.dlo; end
    if (s.wh) begin m_np[s.dh[2:0]] = 1'b0; m_wp[s.dh] = 1'b0; end
    if (s.wl) begin m_np[s.dl[2:0]] = 1'b0; m_wp[s.dl] = 1'b0; end
    if (s.iv && s.iwl) begin m_np[s.idl[2:0]] = 1'b1; m_wp[s.idl] = 1'b1; end
    if (s.iv && s.iwh) begin m_np[s.idh[2:0]] = 1'b1; m_wp[s.idh] = 1'b1; end
  endtask

  // One cycle: apply nx (and reset level) just after the edge, queue the
  // expected outputs for this cycle, then advance the model over the next edge.
  task automatic step(input bit rst_v);
    exp_t e;
    @(posedge clk);
    #1;
    s     = nx;
    reset = rst_v;
    if (rst_v) model_clear();
    e.src1 = n_rd(s.src[2:0], 1'b1);  e.dst1 = n_rd(s.dst[2:0], 1'b1);
    e.src0 = n_rd(s.src[2:0], 1'b0);  e.dst0 = n_rd(s.dst[2:0], 1'b0);
    e.srcw = w_rd(s.src);             e.dstw = w_rd(s.dst);
    e.sb1 = m_np[s.src[2:0]] && !n_wr_hits(s.src[2:0]);
    e.db1 = m_np[s.dst[2:0]] && !n_wr_hits(s.dst[2:0]);
    e.sb0 = m_np[s.src[2:0]];
    e.db0 = m_np[s.dst[2:0]];
    e.sbw = m_wp[s.src] && !w_wr_hits(s.src);
    e.dbw = m_wp[s.dst] && !w_wr_hits(s.dst);
    e.pn  = m_np;
    e.pw  = m_wp;
    q.push_back(e);
    if (!rst_v) model_edge();
  endtask

  // ---------------- monitor ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("b1_src",  {16'h0, if_b1.reg1_read_src}, e.src1);
        chk("b1_dst",  {16'h0, if_b1.reg2_read_dst}, e.dst1);
        chk("b1_sbusy", {31'h0, if_b1.src_busy}, {31'h0, e.sb1});
        chk("b1_dbusy", {31'h0, if_b1.dst_busy}, {31'h0, e.db1});
        chk("b1_hazard", {31'h0, if_b1.hazard}, {31'h0, e.sb1 | e.db1});
        chk("b1_pending", {24'h0, if_b1.pending}, {24'h0, e.pn});
        chk("b0_src",  {16'h0, if_b0.reg1_read_src}, e.src0);
        chk("b0_dst",  {16'h0, if_b0.reg2_read_dst}, e.dst0);
        chk("b0_sbusy", {31'h0, if_b0.src_busy}, {31'h0, e.sb0});
        chk("b0_dbusy", {31'h0, if_b0.dst_busy}, {31'h0, e.db0});
        chk("b0_hazard", {31'h0, if_b0.hazard}, {31'h0, e.sb0 | e.db0});
        chk("b0_pending", {24'h0, if_b0.pending}, {24'h0, e.pn});
        chk("w_src",   if_w.reg1_read_src, e.srcw);
        chk("w_dst",   if_w.reg2_read_dst, e.dstw);
        chk("w_sbusy", {31'h0, if_w.src_busy}, {31'h0, e.sbw});
        chk("w_dbusy", {31'h0, if_w.dst_busy}, {31'h0, e.dbw});
        chk("w_hazard", {31'h0, if_w.hazard}, {31'h0, e.sbw | e.dbw});
        chk("w_pending", {16'h0, if_w.pending}, {16'h0, e.pw});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    reset = 1'b1;
    s  = '0;
    nx = '0;
    model_clear();

    // Reset held, then release and read every index with enables low
    step(1'b1);
    step(1'b1);
    for (int i = 0; i < 16; i++) begin
      nx = '0; nx.src = 4'(i); nx.dst = 4'(15 - i);
      step(1'b0);
    end

    // Wide configuration: only R15 written, everything else still zero
    nx = '0; nx.wl = 1'b1; nx.dl = 4'd15; nx.dlo = 32'hDEADBEEF; nx.src = 4'd15;
    step(1'b0);
    for (int i = 0; i < 16; i++) begin
      nx = '0; nx.src = 4'(i); nx.dst = 4'(15 - i);
      step(1'b0);
    end

    // Asynchronous reset mid-cycle to start the directed cases clean
    nx = '0;
    step(1'b1);

    // Dual write to the same target: low data wins
    nx = '0; nx.wl = 1'b1; nx.dl = 4'd3; nx.dlo = 32'hAAAA;
    nx.wh = 1'b1; nx.dh = 4'd3; nx.dhi = 32'h5555; nx.src = 4'd3;
    step(1'b0);
    nx = '0; nx.src = 4'd3; nx.dst = 4'd3;
    step(1'b0);

    // Dual write to distinct targets
    nx = '0; nx.wl = 1'b1; nx.dl = 4'd1; nx.dlo = 32'h1234;
    nx.wh = 1'b1; nx.dh = 4'd2; nx.dhi = 32'hFFFF; nx.src = 4'd1; nx.dst = 4'd2;
    step(1'b0);
    nx = '0; nx.src = 4'd1; nx.dst = 4'd2;
    step(1'b0);

    // Bypass: read idx5 during its write, then the cycle after
    nx = '0; nx.src = 4'd5; nx.wl = 1'b1; nx.dl = 4'd5; nx.dlo = 32'hBEEF;
    step(1'b0);
    nx = '0; nx.src = 4'd5;
    step(1'b0);

    // Scoreboard lifecycle: MUL issue to 4/6, read 4, writeback 4 only
    nx = '0; nx.iv = 1'b1; nx.iwl = 1'b1; nx.iwh = 1'b1; nx.idl = 4'd4; nx.idh = 4'd6;
    step(1'b0);
    nx = '0; nx.src = 4'd4; nx.dst = 4'd0;
    step(1'b0);
    nx = '0; nx.src = 4'd4; nx.dst = 4'd6; nx.wl = 1'b1; nx.dl = 4'd4; nx.dlo = 32'h0042;
    step(1'b0);
    nx = '0; nx.src = 4'd4; nx.dst = 4'd6;
    step(1'b0);

    // Issue with both targets equal, then set/clear collision on idx2
    nx = '0; nx.iv = 1'b1; nx.iwl = 1'b1; nx.iwh = 1'b1; nx.idl = 4'd2; nx.idh = 4'd2;
    step(1'b0);
    nx = '0; nx.iv = 1'b1; nx.iwl = 1'b1; nx.idl = 4'd2;
    nx.wl = 1'b1; nx.dl = 4'd2; nx.dlo = 32'h7777; nx.src = 4'd2;
    step(1'b0);
    nx = '0; nx.src = 4'd2; nx.dst = 4'd2;
    step(1'b0);

    // Randomized traffic with occasional mid-operation resets
    for (int c = 0; c < 400; c++) begin
      nx.src = 4'($urandom);  nx.dst = 4'($urandom);
      nx.wl  = 1'($urandom);  nx.dl  = 4'($urandom);  nx.dlo = $urandom;
      nx.wh  = 1'($urandom);  nx.dh  = 4'($urandom);  nx.dhi = $urandom;
      nx.iv  = 1'($urandom);  nx.iwl = 1'($urandom);  nx.iwh = 1'($urandom);
      nx.idl = 4'($urandom);  nx.idh = 4'($urandom);
      if (c < 8) nx.dl = nx.dh;
      step($urandom_range(0, 39) == 0);
    end

    nx = '0;
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
